// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width convention and Gray/binary conversions.
// Functions work on a fixed 32-bit container; callers cast to their pointer width.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    // Pointers carry one extra wrap bit above the address width.
    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_lvl_gray2bin_comb.sv
// Combinational Gray-to-binary converter; shared by the read and write pointer blocks.
module gray2bin_comb #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it; computed per bit
    // so no bit depends on another output bit.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign bin[gi] = ^gray[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty flag, fill level, almost-empty and sticky underflow
// for the async FIFO; everything here runs on rclk.
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int ASIZE    = 4,
    parameter int AE_RESET = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    input  logic [ASIZE:0]   rae_thresh,
    input  logic             rae_thresh_we,
    input  logic             rclr_uf,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int PW = ptr_width(ASIZE);

    logic [PW-1:0] rbin_reg;
    logic [PW-1:0] rptr_reg;
    logic          rempty_reg;
    logic          raempty_reg;
    logic [PW-1:0] rlevel_reg;
    logic          runderflow_reg;
    logic [PW-1:0] thr_reg;

    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] thr_eff;
    logic          pop;

    gray2bin_comb #(.W(PW)) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    assign pop        = rinc & ~rempty_reg;
    assign rbin_next  = rbin_reg + PW'(pop);
    assign rgray_next = PW'(bin2gray(32'(rbin_next)));
    // Modular subtraction: the wrap bit makes full (2**ASIZE) distinct from empty (0).
    assign level_next = wbin - rbin_next;
    // A threshold written this cycle already governs this cycle's compare.
    assign thr_eff    = rae_thresh_we ? rae_thresh : thr_reg;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_reg       <= '0;
            rptr_reg       <= '0;
            rempty_reg     <= 1'b1;
            raempty_reg    <= 1'b1;
            rlevel_reg     <= '0;
            runderflow_reg <= 1'b0;
            thr_reg        <= PW'(AE_RESET);
        end else begin
            rbin_reg       <= rbin_next;
            rptr_reg       <= rgray_next;
            rempty_reg     <= (rgray_next == rq2_wptr);
            raempty_reg    <= (level_next <= thr_eff);
            rlevel_reg     <= level_next;
            // Set beats clear when both happen in the same cycle.
            runderflow_reg <= (rinc & rempty_reg) | (runderflow_reg & ~rclr_uf);
            if (rae_thresh_we) begin
                thr_reg <= rae_thresh;
            end
        end
    end

    assign raddr      = rbin_reg[ASIZE-1:0];
    assign rptr       = rptr_reg;
    assign rempty     = rempty_reg;
    assign raempty    = raempty_reg;
    assign rlevel     = rlevel_reg;
    assign runderflow = runderflow_reg;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl (ASIZE=4, AE_RESET=1) with hand-computed expectations.
module tb_rptr_empty_lvl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic [4:0] rae_thresh;
    logic       rae_thresh_we;
    logic       rclr_uf;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;

    int checks = 0;
    int errors = 0;

    rptr_empty_lvl #(.ASIZE(4), .AE_RESET(1)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .rae_thresh    (rae_thresh),
        .rae_thresh_we (rae_thresh_we),
        .rclr_uf       (rclr_uf),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .raempty       (raempty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    always #5 rclk = ~rclk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst = 1'b1; rinc = 1'b0; rclr_uf = 1'b0; rae_thresh_we = 1'b0;
        rq2_wptr = 5'b00000; rae_thresh = 5'd0;
        step();
        step();
        rrst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL %s_rempty got %b exp 1", tag, rempty); end
        checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL %s_raempty got %b exp 1", tag, raempty); end
        checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL %s_rlevel got %0d exp 0", tag, rlevel); end
        checks++; if (rptr !== 5'b00000) begin errors++; $display("FAIL %s_rptr got %b exp 00000", tag, rptr); end
        checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL %s_raddr got %0d exp 0", tag, raddr); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL %s_runderflow got %b exp 0", tag, runderflow); end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_state("reset");
        $display("reset: rempty=%b raempty=%b rlevel=%0d rptr=%b", rempty, raempty, rlevel, rptr);
    endtask

    task automatic test_fill_thresh();
        rq2_wptr = 5'b00010; rae_thresh = 5'd2; rae_thresh_we = 1'b1; rinc = 1'b0;
        step();
        rae_thresh_we = 1'b0;
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty got %b exp 0", rempty); end
        checks++; if (rlevel !== 5'd3) begin errors++; $display("FAIL fill_rlevel got %0d exp 3", rlevel); end
        checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL fill_raempty got %b exp 0", raempty); end
        $display("fill: rlevel=%0d rempty=%b raempty=%b", rlevel, rempty, raempty);
    endtask

    task automatic test_drain();
        logic [4:0] exp_lvl  [3] = '{5'd2, 5'd1, 5'd0};
        logic [4:0] exp_ptr  [3] = '{5'b00001, 5'b00011, 5'b00010};
        logic [3:0] exp_addr [3] = '{4'd1, 4'd2, 4'd3};
        logic       exp_emp  [3] = '{1'b0, 1'b0, 1'b1};
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rlevel !== exp_lvl[i]) begin errors++; $display("FAIL drain%0d_rlevel got %0d exp %0d", i, rlevel, exp_lvl[i]); end
            checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL drain%0d_raempty got %b exp 1", i, raempty); end
            checks++; if (rempty !== exp_emp[i]) begin errors++; $display("FAIL drain%0d_rempty got %b exp %b", i, rempty, exp_emp[i]); end
            checks++; if (rptr !== exp_ptr[i]) begin errors++; $display("FAIL drain%0d_rptr got %b exp %b", i, rptr, exp_ptr[i]); end
            checks++; if (raddr !== exp_addr[i]) begin errors++; $display("FAIL drain%0d_raddr got %0d exp %0d", i, raddr, exp_addr[i]); end
            $display("drain %0d: rlevel=%0d rptr=%b raddr=%0d rempty=%b", i, rlevel, rptr, raddr, rempty);
        end
    endtask

    task automatic test_underflow();
        // Still empty with rinc high: pointer holds, flag sets.
        step();
        rinc = 1'b0;
        checks++; if (raddr !== 4'd3) begin errors++; $display("FAIL uf_raddr got %0d exp 3", raddr); end
        checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL uf_rptr got %b exp 00010", rptr); end
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", runderflow); end
        step();
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_hold got %b exp 1", runderflow); end
        rclr_uf = 1'b1;
        step();
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", runderflow); end
        rinc = 1'b1;
        step();
        rinc = 1'b0; rclr_uf = 1'b0;
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_setwins got %b exp 1", runderflow); end
        rclr_uf = 1'b1;
        step();
        rclr_uf = 1'b0;
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear2 got %b exp 0", runderflow); end
        $display("underflow: set/hold/clear/set-wins sequence done, runderflow=%b", runderflow);
    endtask

    task automatic test_full_level();
        do_reset();
        rq2_wptr = 5'b11000;
        step();
        checks++; if (rlevel !== 5'd16) begin errors++; $display("FAIL full_rlevel got %0d exp 16", rlevel); end
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL full_rempty got %b exp 0", rempty); end
        checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL full_raempty got %b exp 0", raempty); end
        // Threshold at depth forces almost-empty even when full.
        rae_thresh = 5'd16; rae_thresh_we = 1'b1;
        step();
        rae_thresh_we = 1'b0;
        checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL full_thr16_raempty got %b exp 1", raempty); end
        // Threshold 0 makes almost-empty track empty.
        rae_thresh = 5'd0; rae_thresh_we = 1'b1;
        step();
        rae_thresh_we = 1'b0;
        checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL full_thr0_raempty got %b exp 0", raempty); end
        $display("full: rlevel=%0d rempty=%b raempty=%b", rlevel, rempty, raempty);
    endtask

    task automatic test_wrap();
        do_reset();
        rq2_wptr = 5'b11000;              // gray(16)
        step();
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) step();
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL wrapA_rempty got %b exp 1", rempty); end
        checks++; if (rptr !== 5'b11000) begin errors++; $display("FAIL wrapA_rptr got %b exp 11000", rptr); end
        rq2_wptr = 5'b10000;              // gray(31)
        step();
        checks++; if (rlevel !== 5'd15) begin errors++; $display("FAIL wrapB_rlevel got %0d exp 15", rlevel); end
        rinc = 1'b1;
        for (int i = 0; i < 15; i++) step();
        rinc = 1'b0;
        checks++; if (raddr !== 4'd15) begin errors++; $display("FAIL wrapB_raddr got %0d exp 15", raddr); end
        checks++; if (rptr !== 5'b10000) begin errors++; $display("FAIL wrapB_rptr got %b exp 10000", rptr); end
        rq2_wptr = 5'b00000;              // gray(0) == gray(32)
        step();
        checks++; if (rlevel !== 5'd1) begin errors++; $display("FAIL wrapC_rlevel got %0d exp 1", rlevel); end
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL wrapC_rempty got %b exp 0", rempty); end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (rptr !== 5'b00000) begin errors++; $display("FAIL wrap_rptr got %b exp 00000", rptr); end
        checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL wrap_raddr got %0d exp 0", raddr); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL wrap_rempty got %b exp 1", rempty); end
        checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL wrap_rlevel got %0d exp 0", rlevel); end
        $display("wrap: rptr=%b raddr=%0d rempty=%b rlevel=%0d", rptr, raddr, rempty, rlevel);
    endtask

    task automatic test_midop_reset();
        do_reset();
        rq2_wptr = 5'b00111;              // gray(5)
        step();
        rinc = 1'b1;
        step();                           // one read: level 4, rbin 1
        checks++; if (rlevel !== 5'd4) begin errors++; $display("FAIL mid_pre_rlevel got %0d exp 4", rlevel); end
        rinc = 1'b0;
        step();
        // Threshold default is 1, so level 4 is not almost-empty.
        checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL mid_pre_raempty got %b exp 0", raempty); end
        rrst = 1'b1; rinc = 1'b1;
        step();
        rrst = 1'b0; rinc = 1'b0; rq2_wptr = 5'b00000;
        check_reset_state("midrst");
        // Default threshold restored: level 1 must read as almost-empty.
        rq2_wptr = 5'b00001;
        step();
        checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL midrst_thr_raempty got %b exp 1", raempty); end
        checks++; if (rlevel !== 5'd1) begin errors++; $display("FAIL midrst_rlevel got %0d exp 1", rlevel); end
        $display("midop reset: rlevel=%0d raempty=%b", rlevel, raempty);
    endtask

    initial begin
        test_reset();
        test_fill_thresh();
        test_drain();
        test_underflow();
        test_full_level();
        test_wrap();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rptr_empty_lvl.md
Name: rptr_empty_lvl

Overview:
Read-side pointer and empty-flag generator for the async FIFO, and the parametrised successor of the basic read-pointer/empty block. It adds a registered fill level, a programmable almost-empty flag and a sticky underflow flag.
- Lives entirely in the read clock domain.
- Consumes the write pointer after it has been Gray-synchronised into this domain.
- Produces the binary memory read address and the Gray read pointer for synchronisation back to the write side.

Parameters:
ASIZE, 4, address width; FIFO depth = 2**ASIZE; pointers are ASIZE+1 bits (extra wrap bit).
AE_RESET, 1, reset/default almost-empty threshold, used when rae_thresh_we has never been pulsed.

Ports:
rclk  input  1  read-domain clock, all logic on posedge
rrst  input  1  synchronous active-high reset
rinc  input  1  read request; pops one word when rempty=0
rq2_wptr  input  ASIZE+1  write pointer (Gray) synchronised into rclk domain
rae_thresh  input  ASIZE+1  almost-empty threshold value
rae_thresh_we  input  1  load rae_thresh into internal threshold register
rclr_uf  input  1  clears sticky underflow flag
raddr  output  ASIZE  binary memory read address
rptr  output  ASIZE+1  Gray read pointer to write domain
rempty  output  1  FIFO empty
raempty  output  1  level <= threshold
rlevel  output  ASIZE+1  words available, 0..2**ASIZE
runderflow  output  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: single clock rclk. Reset rrst is synchronous, active-high, sampled on posedge rclk, and has priority over all other inputs.
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0, thr=AE_RESET.
- Pointers:
  - rbinnext = rbin + (rinc & ~rempty), modulo 2**(ASIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Registered each cycle: rbin<=rbinnext, rptr<=rgraynext.
  - raddr = rbin[ASIZE-1:0], combinational from the register.
- Empty: rempty <= (rgraynext == rq2_wptr).
  - A read of the last word asserts rempty on the same edge that advances the pointer.
  - A new write pointer clears rempty one rclk after rq2_wptr changes.
- Level:
  - wbin = Gray-to-binary(rq2_wptr), combinational.
  - rlevel <= wbin - rbinnext, modulo 2**(ASIZE+1).
  - Valid range is 0..2**ASIZE; full reads as 2**ASIZE (e.g. 16 for ASIZE=4).
  - Latency is identical to rempty, so rempty==1 iff rlevel==0 in every cycle.
- Almost-empty:
  - thr <= rae_thresh when rae_thresh_we=1.
  - raempty <= ((wbin - rbinnext) <= thr_eff), where thr_eff = rae_thresh if rae_thresh_we is high this cycle, else thr (write-through).
  - Unsigned compare. thr=0 makes raempty equal rempty. thr >= 2**ASIZE forces raempty=1 permanently.
- Underflow:
  - If rinc=1 and rempty=1, the pointer is unchanged and runderflow <= 1 on the next edge.
  - runderflow is sticky until rclr_uf=1.
  - If rclr_uf and a new underflow occur in the same cycle, set wins: runderflow stays 1.
- Wrap-around: the pointer wraps from 2**(ASIZE+1)-1 to 0 with no special casing. The MSB toggle distinguishes a full FIFO from an empty one for level math.
- Reset mid-operation: all state returns to reset values on the next edge regardless of rinc or rq2_wptr. The Gray-to-binary function of rq2_wptr remains combinational only.
- Unknown or non-Gray rq2_wptr is out of contract. The synchroniser guarantees a single-bit change per write.

Decomposition:
- Shared package fifo_pkg holds the bin2gray and gray2bin functions, parametrised by width via an automatic function with a fixed max width or a parameter-typed wrapper.
- The package also holds the ptr_t width convention (ASIZE+1).
- One natural sub-module: gray2bin_comb (parameter W), a combinational XOR prefix chain. It is reused by the write-side wptr_full_lvl.
- The rest stays flat: pointer register, compare, subtract, flags.

Test Plan:
- Reset (ASIZE=4, AE_RESET=1), rrst=1 for 2 cycles -> rempty=1, raempty=1, rlevel=0, rptr=5'b00000, raddr=0, runderflow=0.
- Fill and threshold: rq2_wptr=gray(3)=5'b00010, rae_thresh=2 with we pulse, rinc=0 -> next edge rempty=0, rlevel=3, raempty=0.
- Drain:
  - Issue rinc=1 for 3 cycles.
  - rlevel goes 2, 1, 0; raempty goes 1, 1, 1; rempty=1 on the 3rd edge.
  - rptr goes 00001, 00011, 00010; raddr goes 1, 2, 3.
- Full level: rbin=0, rq2_wptr=gray(16)=5'b11000 -> rlevel=16, rempty=0, raempty=0 (thr=2).
- Wrap: rbin=31, rq2_wptr=gray(0), one read -> rptr=5'b00000, raddr=0, rempty=1, rlevel=0.
- Underflow and mid-op reset:
  - rinc=1 while empty -> rbin unchanged, runderflow=1 next edge, held.
  - rclr_uf=1 with rinc=0 -> runderflow=0.
  - With rlevel=5, assert rrst -> next edge all outputs at reset values.
